dma_reg_slave: RTL and testbench

Register-bus responder for the DMA block: the target end of the single-cycle wr_en/rd_en/addr/wdata/rdata bus the UVM driver and RAL model initiate on. It holds the DMA programming registers and a small transfer engine that models a transfer by counting words, so the RAL sequences have real volatile, self-clearing and W1C fields to exercise.

---
 rtl/dma_reg_pkg.sv | 41 ++++
 rtl/dma_xfer_engine.sv | 66 ++++++
 rtl/dma_reg_slave.sv | 149 ++++++++++++++
 tb/tb_dma_reg_slave.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_reg_pkg.sv
// Shared definitions for the DMA register slave: register offsets, field positions,
// engine state encoding and the STATUS register layout.
package dma_reg_pkg;

  localparam logic [31:0] OFS_CTRL       = 32'h00;
  localparam logic [31:0] OFS_SRC_ADDR   = 32'h04;
  localparam logic [31:0] OFS_DST_ADDR   = 32'h08;
  localparam logic [31:0] OFS_TRANS_SIZE = 32'h0C;
  localparam logic [31:0] OFS_STATUS     = 32'h10;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_INTR_EN_BIT = 1;
  localparam int CTRL_ABORT_BIT   = 2;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
  localparam int STATUS_ERR_BIT  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } xfer_state_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_SRC,
    SEL_DST,
    SEL_SIZE,
    SEL_STATUS
  } reg_sel_e;

  typedef struct packed {
    logic [15:0] remaining;
    logic [12:0] rsvd;
    logic        err;
    logic        done;
    logic        busy;
  } status_t;

endpackage

// File: rtl/dma_xfer_engine.sv
// Transfer engine: counts one word per cycle from the programmed size down to zero.
// Accepts start/abort every cycle with no backpressure; done/err pulses are strobes for the edge they occur on.
module dma_xfer_engine
  import dma_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] size,
  output logic        busy,
  output logic [15:0] remaining,
  output logic        done_pulse,
  output logic        err_pulse
);

  xfer_state_e state_q, state_d;
  logic [15:0] rem_q, rem_d;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    done_pulse = 1'b0;
    err_pulse  = 1'b0;
    case (state_q)
      IDLE: begin
        // abort in the same write as start cancels the start; abort alone is a no-op when idle
        if (start && !abort) begin
          if (size == 16'd0) begin
            err_pulse = 1'b1;
          end else begin
            state_d = BUSY;
            rem_d   = size;
          end
        end
      end
      BUSY: begin
        if (abort) begin
          state_d   = IDLE;
          err_pulse = 1'b1;
        end else if (rem_q <= 16'd1) begin
          state_d    = IDLE;
          rem_d      = 16'd0;
          done_pulse = 1'b1;
        end else begin
          rem_d = rem_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  assign busy      = (state_q == BUSY);
  assign remaining = rem_q;

endmodule

// File: rtl/dma_reg_slave.sv
// DMA register-bus target: decode, register bank, W1C status and the transfer engine.
// Writes take effect at the capturing edge, reads return one cycle later; the bus never stalls.
module dma_reg_slave
  import dma_reg_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              irq
);

  logic [ADDR_W-1:0] offs;
  reg_sel_e          sel;

  logic              intr_en_q, intr_en_d;
  logic [DATA_W-1:0] src_q, src_d;
  logic [DATA_W-1:0] dst_q, dst_d;
  logic [15:0]       size_q, size_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              eng_busy;
  logic [15:0]       eng_rem;
  logic              eng_done;
  logic              eng_err;

  logic              wr_ctrl;
  logic              start_req;
  logic              abort_req;
  logic              start_ok;
  logic [2:0]        ctrl_rd;
  status_t           status;
  logic [DATA_W-1:0] rd_val;

  // Misaligned addresses never equal an aligned offset, so they fall through to SEL_NONE.
  assign offs = addr - BASE_ADDR;

  always_comb begin
    sel = SEL_NONE;
    if      (offs == ADDR_W'(OFS_CTRL))       sel = SEL_CTRL;
    else if (offs == ADDR_W'(OFS_SRC_ADDR))   sel = SEL_SRC;
    else if (offs == ADDR_W'(OFS_DST_ADDR))   sel = SEL_DST;
    else if (offs == ADDR_W'(OFS_TRANS_SIZE)) sel = SEL_SIZE;
    else if (offs == ADDR_W'(OFS_STATUS))     sel = SEL_STATUS;
  end

  assign wr_ctrl   = wr_en && (sel == SEL_CTRL);
  assign start_req = wr_ctrl && wdata[CTRL_START_BIT];
  assign abort_req = wr_ctrl && wdata[CTRL_ABORT_BIT];
  assign start_ok  = start_req && !abort_req && !eng_busy && (size_q != 16'd0);

  dma_xfer_engine u_engine (
    .clk        (clk),
    .rst        (rst_n),
    .start      (start_req),
    .abort      (abort_req),
    .size       (size_q),
    .busy       (eng_busy),
    .remaining  (eng_rem),
    .done_pulse (eng_done),
    .err_pulse  (eng_err)
  );

  always_comb begin
    ctrl_rd                   = 3'b000;
    ctrl_rd[CTRL_INTR_EN_BIT] = intr_en_q;

    status           = '0;
    status.busy      = eng_busy;
    status.done      = done_q;
    status.err       = err_q;
    status.remaining = eng_rem;

    case (sel)
      SEL_CTRL:   rd_val = DATA_W'(ctrl_rd);
      SEL_SRC:    rd_val = src_q;
      SEL_DST:    rd_val = dst_q;
      SEL_SIZE:   rd_val = DATA_W'(size_q);
      SEL_STATUS: rd_val = DATA_W'(status);
      default:    rd_val = '0;
    endcase
  end

  always_comb begin
    intr_en_d = intr_en_q;
    src_d     = src_q;
    dst_d     = dst_q;
    size_d    = size_q;
    done_d    = done_q;
    err_d     = err_q;

    if (wr_ctrl) intr_en_d = wdata[CTRL_INTR_EN_BIT];

    // Transfer parameters are locked while the engine is running.
    if (wr_en && !eng_busy) begin
      if (sel == SEL_SRC)  src_d  = wdata;
      if (sel == SEL_DST)  dst_d  = wdata;
      if (sel == SEL_SIZE) size_d = wdata[15:0];
    end

    if (wr_en && (sel == SEL_STATUS)) begin
      if (wdata[STATUS_DONE_BIT]) done_d = 1'b0;
      if (wdata[STATUS_ERR_BIT])  err_d  = 1'b0;
    end

    if (start_ok) done_d = 1'b0;

    // Hardware events are applied last so they win over a same-cycle W1C.
    if (eng_done) done_d = 1'b1;
    if (eng_err)  err_d  = 1'b1;

    rdata_d = rd_en ? rd_val : rdata_q;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      intr_en_q <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      size_q    <= 16'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      intr_en_q <= intr_en_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      size_q    <= size_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign busy  = eng_busy;
  assign irq   = intr_en_q & done_q;

endmodule

// File: tb/tb_dma_reg_slave.sv
// Directed bench for dma_reg_slave: a vector table for basic register access,
// then hand-written sequences for transfer, abort, W1C races and reset.
module tb_dma_reg_slave;

  localparam logic [31:0] BASE     = 32'h0000_0400;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_SRC    = BASE + 32'h04;
  localparam logic [31:0] A_DST    = BASE + 32'h08;
  localparam logic [31:0] A_SIZE   = BASE + 32'h0C;
  localparam logic [31:0] A_STATUS = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        busy;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] a;
    logic [31:0] d;
    logic        chk;
    logic [31:0] exp;
    logic        ebusy;
    logic        eirq;
  } vec_t;

  vec_t vq[$];

  dma_reg_slave #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .BASE_ADDR (BASE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .busy  (busy),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // One bus cycle: drive, let one rising edge capture it, return 1 time unit later.
  task automatic bus(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    wr_en = w;
    rd_en = r;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    bus(1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic add(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                     input logic c, input logic [31:0] e);
    vec_t v;
    v.wr = w; v.rd = r; v.a = a; v.d = d; v.chk = c; v.exp = e;
    v.ebusy = 1'b0; v.eirq = 1'b0;
    vq.push_back(v);
  endtask

  initial begin
    add(0, 1, A_CTRL,          32'h0,         1, 32'h0);
    add(0, 1, A_SRC,           32'h0,         1, 32'h0);
    add(0, 1, A_DST,           32'h0,         1, 32'h0);
    add(0, 1, A_SIZE,          32'h0,         1, 32'h0);
    add(0, 1, A_STATUS,        32'h0,         1, 32'h0);
    add(0, 1, BASE + 32'h14,   32'h0,         1, 32'h0);
    add(1, 0, A_SRC,           32'hA5A5_0000, 0, 32'h0);
    add(1, 0, A_DST,           32'h0000_5A5A, 0, 32'h0);
    add(1, 0, A_SIZE,          32'h0001_0003, 0, 32'h0);
    add(0, 1, A_SRC,           32'h0,         1, 32'hA5A5_0000);
    add(0, 1, A_DST,           32'h0,         1, 32'h0000_5A5A);
    add(0, 1, A_SIZE,          32'h0,         1, 32'h0000_0003);
    add(0, 1, 32'h0000_03F4,   32'h0,         1, 32'h0);
    add(1, 0, A_SRC + 32'h1,   32'hDEAD_BEEF, 0, 32'h0);
    add(0, 1, A_SRC,           32'h0,         1, 32'hA5A5_0000);
    add(0, 1, A_SRC + 32'h1,   32'h0,         1, 32'h0);
    add(1, 0, A_CTRL,          32'h0000_0002, 0, 32'h0);
    add(0, 1, A_CTRL,          32'h0,         1, 32'h0000_0002);
    add(0, 1, A_STATUS,        32'h0,         1, 32'h0);

    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset rdata", rdata, 32'h0);
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset irq", {31'b0, irq}, 32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      bus(vq[i].wr, vq[i].rd, vq[i].a, vq[i].d);
      if (vq[i].chk) check($sformatf("vec%0d rdata", i), rdata, vq[i].exp);
      check($sformatf("vec%0d busy", i), {31'b0, busy}, {31'b0, vq[i].ebusy});
      check($sformatf("vec%0d irq", i), {31'b0, irq}, {31'b0, vq[i].eirq});
    end

    // Normal 4-word transfer with interrupt enabled
    wr(A_SIZE, 32'd4);
    wr(A_CTRL, 32'h3);
    check("xfer busy e0", {31'b0, busy}, 32'h1);
    idle();
    check("xfer busy e1", {31'b0, busy}, 32'h1);
    rd(A_STATUS);
    check("xfer status e2", rdata, 32'h0003_0001);
    check("xfer busy e2", {31'b0, busy}, 32'h1);
    rd(A_STATUS);
    check("xfer status e3", rdata, 32'h0002_0001);
    check("xfer busy e3", {31'b0, busy}, 32'h1);
    rd(A_STATUS);
    check("xfer status e4", rdata, 32'h0001_0001);
    check("xfer busy e4", {31'b0, busy}, 32'h0);
    check("xfer irq e4", {31'b0, irq}, 32'h1);
    rd(A_STATUS);
    check("xfer status done", rdata, 32'h0000_0002);
    check("xfer irq done", {31'b0, irq}, 32'h1);
    wr(A_STATUS, 32'h2);
    check("w1c irq", {31'b0, irq}, 32'h0);
    rd(A_STATUS);
    check("w1c status", rdata, 32'h0);
    rd(A_CTRL);
    check("ctrl start selfclr", rdata, 32'h2);

    // Zero-size start
    wr(A_SIZE, 32'd0);
    wr(A_CTRL, 32'h3);
    check("size0 busy e0", {31'b0, busy}, 32'h0);
    idle();
    check("size0 busy e1", {31'b0, busy}, 32'h0);
    rd(A_STATUS);
    check("size0 status", rdata, 32'h0000_0004);
    check("size0 irq", {31'b0, irq}, 32'h0);
    wr(A_STATUS, 32'h4);
    rd(A_STATUS);
    check("size0 err clr", rdata, 32'h0);

    // done set by hardware on the same edge as its W1C
    wr(A_SIZE, 32'd2);
    wr(A_CTRL, 32'h3);
    idle();
    wr(A_STATUS, 32'h2);
    check("race busy", {31'b0, busy}, 32'h0);
    check("race irq", {31'b0, irq}, 32'h1);
    rd(A_STATUS);
    check("race status", rdata, 32'h0000_0002);
    wr(A_STATUS, 32'h2);

    // SIZE write while busy is dropped
    wr(A_SIZE, 32'd5);
    wr(A_CTRL, 32'h3);
    wr(A_SIZE, 32'd9);
    rd(A_SIZE);
    check("size locked", rdata, 32'd5);
    repeat (6) idle();
    check("size5 busy end", {31'b0, busy}, 32'h0);
    wr(A_STATUS, 32'h6);

    // Abort after ten counting cycles
    wr(A_SIZE, 32'd100);
    wr(A_CTRL, 32'h1);
    repeat (10) idle();
    check("abort busy pre", {31'b0, busy}, 32'h1);
    wr(A_CTRL, 32'h4);
    check("abort busy", {31'b0, busy}, 32'h0);
    check("abort irq", {31'b0, irq}, 32'h0);
    rd(A_STATUS);
    check("abort status", rdata, 32'h005A_0004);
    wr(A_SIZE, 32'd7);
    rd(A_SIZE);
    check("size after abort", rdata, 32'd7);
    wr(A_STATUS, 32'h4);
    rd(A_STATUS);
    check("abort err clr", rdata, 32'h005A_0000);
    wr(A_CTRL, 32'h5);
    check("start+abort busy", {31'b0, busy}, 32'h0);
    rd(A_STATUS);
    check("start+abort status", rdata, 32'h005A_0000);

    // Reset in the middle of a transfer
    wr(A_SIZE, 32'd50);
    wr(A_CTRL, 32'h1);
    repeat (3) idle();
    rd(A_SRC);
    check("pre-rst rdata", rdata, 32'hA5A5_0000);
    check("pre-rst busy", {31'b0, busy}, 32'h1);
    #2;
    rst_n = 1'b1;
    #1;
    check("mid-rst busy", {31'b0, busy}, 32'h0);
    check("mid-rst rdata", rdata, 32'h0);
    check("mid-rst irq", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    rd(A_STATUS);
    check("post-rst status", rdata, 32'h0);
    rd(A_SRC);
    check("post-rst src", rdata, 32'h0);
    repeat (3) idle();
    rd(A_STATUS);
    check("post-rst status late", rdata, 32'h0);

    // Simultaneous write and read returns the pre-write value
    wr(A_SRC, 32'h0000_1111);
    bus(1'b1, 1'b1, A_SRC, 32'h0000_2222);
    check("wr+rd old value", rdata, 32'h0000_1111);
    rd(A_SRC);
    check("wr+rd new value", rdata, 32'h0000_2222);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
